fifo_drain_ctrl: RTL and testbench

- Read-side controller for the team's synchronous FIFO (registered rd_data, 1-cycle read latency, occupancy counter output).
- Decides when to drain: burst threshold reached, idle timeout with residual data, or external flush.
- Sequences fifo_rd_en and presents each word on a valid/ready/last stream toward the DMA/host path.
- Sits between the trace-capture FIFO and the stream sink.

---
 rtl/fifo_drain_pkg.sv | 18 +
 rtl/drain_timeout_timer.sv | 38 +++
 rtl/fifo_drain_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared state encoding and widths for the FIFO drain controller
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } drain_state_e;

  localparam int BURST_CNT_W = 32;

  // Occupancy counter needs one extra bit so that a full FIFO (== DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/drain_timeout_timer.sv
// rtl/drain_timeout_timer.sv - saturating idle timer; expired while holding TIMEOUT_CYCLES-1
module drain_timeout_timer
  import fifo_drain_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clear,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - FIFO read-side burst controller feeding a valid/ready/last stream
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CNT_W         = cnt_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [CNT_W-1:0]       fifo_counter,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   busy,
  output logic                   timeout_pulse,
  output logic [BURST_CNT_W-1:0] burst_count
);

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  drain_state_e           state_q, state_d;
  logic [CNT_W-1:0]       remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [BURST_CNT_W-1:0] burst_count_q, burst_count_d;

  logic has_data, at_threshold, timer_expired, start, timer_inc, timer_clear;

  assign has_data     = (fifo_counter != '0);
  assign at_threshold = (fifo_counter >= BURST_LEN_C);
  assign start        = (state_q == ST_IDLE) && enable && has_data &&
                        (at_threshold || flush || timer_expired);
  // Timer only runs while a partial burst is waiting; any other condition parks it at zero.
  assign timer_inc    = (state_q == ST_IDLE) && enable && has_data && !at_threshold && !flush;
  assign timer_clear  = !timer_inc || start;

  drain_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .inc    (timer_inc),
    .clear  (timer_clear),
    .expired(timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    burst_count_d = burst_count_q;
    fifo_rd_en    = 1'b0;
    timeout_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_REQ;
          remaining_d   = at_threshold ? BURST_LEN_C : fifo_counter;
          timeout_pulse = !at_threshold && !flush;
        end
      end
      ST_REQ: begin
        fifo_rd_en  = 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        tdata_d  = fifo_rd_data;
        tvalid_d = 1'b1;
        tlast_d  = (remaining_q == '0);
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (m_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (remaining_q != '0) begin
            state_d = ST_REQ;
          end else begin
            burst_count_d = burst_count_q + 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      burst_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign m_tdata     = tdata_q;
  assign m_tvalid    = tvalid_q;
  assign m_tlast     = tlast_q;
  assign burst_count = burst_count_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - cycle vectors plus FIFO/sink model sequences for fifo_drain_ctrl
module tb_fifo_drain_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          m_tready = 1'b0;
  logic [CW-1:0] fifo_counter;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en, m_tvalid, m_tlast, busy, timeout_pulse;
  logic [DW-1:0] m_tdata;
  logic [31:0]   burst_count;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(8), .BURST_LEN(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_counter(fifo_counter), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .timeout_pulse(timeout_pulse), .burst_count(burst_count)
  );

  // FIFO source: either driven straight from the vector table or from a small FIFO model
  logic          use_model = 1'b0;
  logic [CW-1:0] tbl_cnt = '0;
  logic [DW-1:0] tbl_rdata = '0;
  logic [DW-1:0] fmem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] model_rdata = '0;

  assign fifo_counter = use_model ? CW'(wr_ptr - rd_ptr) : tbl_cnt;
  assign fifo_rd_data = use_model ? model_rdata : tbl_rdata;

  int            rd_cnt = 0, tp_cnt = 0, got_n = 0, underflow = 0;
  logic [DW-1:0] got_data [0:255];
  logic          got_last [0:255];

  always @(negedge clk) begin
    if (use_model) begin
      if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (wr_ptr == rd_ptr) begin
          underflow <= underflow + 1;
        end else begin
          model_rdata <= fmem[rd_ptr];
          rd_ptr      <= rd_ptr + 1;
        end
      end
      if (timeout_pulse) tp_cnt <= tp_cnt + 1;
      if (m_tvalid && m_tready && !rst) begin
        got_data[got_n] <= m_tdata;
        got_last[got_n] <= m_tlast;
        got_n           <= got_n + 1;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    fmem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_bc(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (burst_count == 32'(target)) break;
      step();
    end
    chk("burst_done_wait", 128'(burst_count), 128'(target));
  endtask

  task automatic chk_words(input string nm, input int base, input int n, input logic [DW-1:0] first);
    chk({nm, "_count"}, 128'(got_n - base), 128'(n));
    for (int i = 0; i < n; i++) begin
      chk({nm, "_word"}, 128'({got_data[base+i], got_last[base+i]}),
          128'({first + DW'(i), (i == n - 1) ? 1'b1 : 1'b0}));
    end
  endtask

  typedef struct {
    logic          chk, rst, en, fl;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rdata;
    logic          rdy, x_rd, x_tv, x_tl, td_chk;
    logic [DW-1:0] x_td;
    logic          x_busy, x_tp;
    logic [31:0]   x_bc;
  } vec_t;

  function automatic vec_t mk(input logic c, r, e, f, input logic [CW-1:0] n, input logic [DW-1:0] rd,
                              input logic rdy, xr, xv, xl, tc, input logic [DW-1:0] xd,
                              input logic xb, xp, input logic [31:0] xc);
    vec_t v;
    v.chk = c; v.rst = r; v.en = e; v.fl = f; v.cnt = n; v.rdata = rd; v.rdy = rdy;
    v.x_rd = xr; v.x_tv = xv; v.x_tl = xl; v.td_chk = tc; v.x_td = xd;
    v.x_busy = xb; v.x_tp = xp; v.x_bc = xc;
    return v;
  endfunction

  vec_t tbl [0:20];

  initial begin
    int b0, r0, t0, found, stall_bad;

    // Threshold burst A0..A3, then flush start, then reset during LOAD
    tbl[0]  = mk(0,1,1,0, 0, 0,     1, 0,0,0,0, 0,     0,0,0);
    tbl[1]  = mk(1,0,1,0, 0, 0,     1, 0,0,0,1, 0,     0,0,0);
    tbl[2]  = mk(1,0,1,0, 4, 0,     1, 0,0,0,0, 0,     0,0,0);
    tbl[3]  = mk(1,0,1,0, 4, 0,     1, 1,0,0,0, 0,     1,0,0);
    tbl[4]  = mk(1,0,1,0, 3, 'hA0,  1, 0,0,0,0, 0,     1,0,0);
    tbl[5]  = mk(1,0,1,0, 3, 'hA0,  1, 0,1,0,1, 'hA0,  1,0,0);
    tbl[6]  = mk(1,0,1,0, 3, 'hA0,  1, 1,0,0,0, 0,     1,0,0);
    tbl[7]  = mk(1,0,1,0, 2, 'hA1,  1, 0,0,0,0, 0,     1,0,0);
    tbl[8]  = mk(1,0,1,0, 2, 'hA1,  1, 0,1,0,1, 'hA1,  1,0,0);
    tbl[9]  = mk(1,0,1,0, 2, 'hA1,  1, 1,0,0,0, 0,     1,0,0);
    tbl[10] = mk(1,0,1,0, 1, 'hA2,  1, 0,0,0,0, 0,     1,0,0);
    tbl[11] = mk(1,0,1,0, 1, 'hA2,  1, 0,1,0,1, 'hA2,  1,0,0);
    tbl[12] = mk(1,0,1,0, 1, 'hA2,  1, 1,0,0,0, 0,     1,0,0);
    tbl[13] = mk(1,0,1,0, 0, 'hA3,  1, 0,0,0,0, 0,     1,0,0);
    tbl[14] = mk(1,0,1,0, 0, 'hA3,  1, 0,1,1,1, 'hA3,  1,0,0);
    tbl[15] = mk(1,0,1,0, 0, 'hA3,  1, 0,0,0,0, 0,     0,0,1);
    tbl[16] = mk(1,0,0,1, 1, 'hA3,  1, 0,0,0,0, 0,     0,0,1);
    tbl[17] = mk(1,0,1,1, 1, 'hA3,  1, 0,0,0,0, 0,     0,0,1);
    tbl[18] = mk(1,0,1,1, 1, 'hA3,  1, 1,0,0,0, 0,     1,0,1);
    tbl[19] = mk(1,1,1,0, 0, 'h5A,  1, 0,0,0,0, 0,     1,0,1);
    tbl[20] = mk(1,0,1,0, 0, 'h5A,  1, 0,0,0,1, 0,     0,0,0);

    for (int i = 0; i <= 20; i++) begin
      step();
      rst = tbl[i].rst; enable = tbl[i].en; flush = tbl[i].fl;
      tbl_cnt = tbl[i].cnt; tbl_rdata = tbl[i].rdata; m_tready = tbl[i].rdy;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d", i),
            128'({fifo_rd_en, m_tvalid, m_tlast, busy, timeout_pulse, burst_count,
                  tbl[i].td_chk ? m_tdata : 32'h0}),
            128'({tbl[i].x_rd, tbl[i].x_tv, tbl[i].x_tl, tbl[i].x_busy, tbl[i].x_tp, tbl[i].x_bc,
                  tbl[i].td_chk ? tbl[i].x_td : 32'h0}));
      end
    end

    step();
    use_model = 1'b1; enable = 1'b1; flush = 1'b0; m_tready = 1'b1; rst = 1'b0;
    step();

    // Timeout: two words wait TIMEOUT_CYCLES cycles, counting the first non-empty cycle
    b0 = got_n; r0 = rd_cnt; t0 = tp_cnt;
    push(32'hB0); push(32'hB1);
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout_pulse) begin found = k; break; end
    end
    chk("timeout_latency", 128'(found), 128'(16));
    wait_bc(1, 30);
    step();
    chk("timeout_pulses", 128'(tp_cnt - t0), 128'(1));
    chk("timeout_reads", 128'(rd_cnt - r0), 128'(2));
    chk_words("timeout", b0, 2, 32'hB0);
    chk("timeout_empty", 128'(fifo_counter), 128'(0));

    // Back-pressure: word 0 held for 5 cycles
    m_tready = 1'b0;
    b0 = got_n; r0 = rd_cnt;
    push(32'hC0); push(32'hC1); push(32'hC2); push(32'hC3);
    found = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (m_tvalid) begin found = k; break; end
    end
    chk("first_valid_latency", 128'(found), 128'(4));
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (!m_tvalid || m_tdata !== 32'hC0 || fifo_rd_en) stall_bad = stall_bad + 1;
    end
    step();
    m_tready = 1'b1;
    chk("bp_stable", 128'(stall_bad), 128'(0));
    chk("bp_reads_during_stall", 128'(rd_cnt - r0), 128'(1));
    wait_bc(2, 40);
    step();
    chk("bp_reads", 128'(rd_cnt - r0), 128'(4));
    chk_words("bp", b0, 4, 32'hC0);

    // Flush with enable low holds off; enable starts a 1-word burst next cycle
    enable = 1'b0; flush = 1'b1;
    b0 = got_n; r0 = rd_cnt; found = 0;
    push(32'hD0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy) found = found + 1;
    end
    chk("flush_disabled_busy", 128'(found), 128'(0));
    chk("flush_disabled_reads", 128'(rd_cnt - r0), 128'(0));
    enable = 1'b1;
    @(negedge clk);
    chk("flush_start_cycle", 128'({busy, timeout_pulse, fifo_rd_en}), 128'(3'b000));
    @(negedge clk);
    chk("flush_req_cycle", 128'({busy, fifo_rd_en}), 128'(2'b11));
    wait_bc(3, 20);
    step();
    flush = 1'b0;
    chk_words("flush", b0, 1, 32'hD0);

    // Enable dropped mid-burst: burst still completes
    b0 = got_n;
    push(32'hE0); push(32'hE1); push(32'hE2); push(32'hE3);
    step();
    enable = 1'b0;
    wait_bc(4, 40);
    step();
    chk_words("en_drop", b0, 4, 32'hE0);
    enable = 1'b1;

    // Concurrent producer writes do not extend the running burst
    b0 = got_n; t0 = tp_cnt;
    push(32'hF0); push(32'hF1); push(32'hF2); push(32'hF3);
    step();
    repeat (2) step();
    push(32'hF4);
    repeat (3) step();
    push(32'hF5);
    repeat (3) step();
    push(32'hF6);
    wait_bc(5, 40);
    chk_words("conc_first", b0, 4, 32'hF0);
    chk("conc_residual", 128'(fifo_counter), 128'(3));
    step();
    b0 = got_n; found = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout_pulse) begin found = k; break; end
      if (busy) break;
    end
    chk("conc_timeout_latency", 128'(found), 128'(15));
    wait_bc(6, 30);
    step();
    chk_words("conc_second", b0, 3, 32'hF4);
    chk("conc_pulses", 128'(tp_cnt - t0), 128'(1));

    // Reset while a word is parked in SEND
    m_tready = 1'b0;
    push(32'h60); push(32'h61); push(32'h62); push(32'h63);
    found = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (m_tvalid) begin found = k; break; end
    end
    chk("rst_reach_send", 128'(found), 128'(4));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; m_tready = 1'b1;
    @(negedge clk);
    chk("rst_mid_burst", 128'({m_tvalid, busy, fifo_rd_en, burst_count}), 128'({3'b000, 32'h0}));
    b0 = got_n;
    step();
    push(32'h64);
    wait_bc(1, 40);
    step();
    chk_words("rst_resume", b0, 4, 32'h61);

    chk("no_empty_reads", 128'(underflow), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
